// File: rtl/axis_write_sched_pkg.sv
// rtl/axis_write_sched_pkg.sv - shared config-bus defaults, FSM states and index-width helper
//
// Purpose: common definitions for the axis_write descriptor scheduler.
//   DEF_CONFIG_*  default engine ID word and config-bus addresses
//   state_e       scheduler FSM state encoding
//   idx_width()   width of an index into n items, never below 1 bit
package axis_write_sched_pkg;

  localparam int DEF_CONFIG_ID   = 1;
  localparam int DEF_CONFIG_ADDR = 23;
  localparam int DEF_CONFIG_DATA = 24;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND_ID   = 3'd1,
    ST_SEND_ADDR = 3'd2,
    ST_SEND_LEN  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_GAP       = 3'd5
  } state_e;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_rr_arbiter.sv
// rtl/axis_rr_arbiter.sv - combinational round-robin arbiter starting from a pointer
//
// Purpose: picks the first asserted request searching ptr, ptr+1, ... modulo
// NUM_REQ. The pointer register belongs to the parent.
// Ports:
//   req_i    request vector
//   ptr_i    highest-priority index for this search
//   grant_o  one-hot grant (zero when no request)
//   idx_o    binary index of the winner
//   any_o    at least one request asserted
module axis_rr_arbiter
  import axis_write_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);

  localparam logic [IW:0] NR_W = (IW+1)'(NUM_REQ);

  // One extra bit so ptr + offset cannot overflow before the modulo wrap.
  logic [IW:0] pos;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    pos     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, ptr_i} + (IW+1)'(k);
      if (pos >= NR_W) begin
        pos = pos - NR_W;
      end
      if (!any_o && req_i[pos[IW-1:0]]) begin
        any_o                   = 1'b1;
        grant_o[pos[IW-1:0]]    = 1'b1;
        idx_o                   = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/axis_write_sched.sv
// rtl/axis_write_sched.sv - round-robin descriptor scheduler feeding one axis_write engine
//
// Purpose: accepts one write descriptor at a time from NUM_REQ requesters,
// programs the engine with ID / address / length config words, waits for the
// engine's done pulse, reports completion, then idles CFG_GAP cycles.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/addr/length per-requester descriptors (fields packed per requester)
//   req_ready             one-hot accept, only while idle
//   done                  engine finished the current stream
//   cfg_addr/data/valid   registered config-bus word to the engine
//   cmpl_valid/cmpl_id    one-cycle completion pulse and requester index
//   busy                  scheduler is not idle
module axis_write_sched
  import axis_write_sched_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int CONFIG_ID     = DEF_CONFIG_ID,
  parameter int CONFIG_ADDR   = DEF_CONFIG_ADDR,
  parameter int CONFIG_DATA   = DEF_CONFIG_DATA,
  parameter int CONFIG_AWIDTH = 5,
  parameter int CONFIG_DWIDTH = 32,
  parameter int CFG_GAP       = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*CONFIG_DWIDTH-1:0] req_addr,
  input  logic [NUM_REQ*CONFIG_DWIDTH-1:0] req_length,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic                             done,
  output logic [CONFIG_AWIDTH-1:0]         cfg_addr,
  output logic [CONFIG_DWIDTH-1:0]         cfg_data,
  output logic                             cfg_valid,
  output logic                             cmpl_valid,
  output logic [idx_width(NUM_REQ)-1:0]    cmpl_id,
  output logic                             busy
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int GW = idx_width(CFG_GAP + 1);
  localparam int DW = CONFIG_DWIDTH;

  localparam logic [IW-1:0]            LAST_IDX = IW'(NUM_REQ - 1);
  localparam logic [GW-1:0]            GAP_LAST = (CFG_GAP > 0) ? GW'(CFG_GAP - 1) : '0;
  localparam logic [CONFIG_AWIDTH-1:0] ID_ADDR  = CONFIG_AWIDTH'(CONFIG_ADDR);
  localparam logic [CONFIG_AWIDTH-1:0] DAT_ADDR = CONFIG_AWIDTH'(CONFIG_DATA);
  localparam logic [DW-1:0]            ID_WORD  = DW'(CONFIG_ID);

  state_e                   state_q;
  logic [IW-1:0]            p_q;
  logic [IW-1:0]            id_q;
  logic [DW-1:0]            addr_q;
  logic [DW-1:0]            len_q;
  logic [GW-1:0]            gap_q;
  logic                     cfg_valid_q;
  logic [CONFIG_AWIDTH-1:0] cfg_addr_q;
  logic [DW-1:0]            cfg_data_q;
  logic                     cmpl_valid_q;
  logic [IW-1:0]            cmpl_id_q;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;
  logic [DW-1:0]      sel_addr;
  logic [DW-1:0]      sel_len;

  axis_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .req_i   (req_valid),
    .ptr_i   (p_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  // Fields of the winning requester, selected by constant slices.
  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_addr = req_addr[i*DW +: DW];
        sel_len  = req_length[i*DW +: DW];
      end
    end
  end

  // Gated by rst_n so no accept is advertised while reset is held.
  assign req_ready  = (rst_n && state_q == ST_IDLE) ? arb_grant : '0;
  assign busy       = (state_q != ST_IDLE);
  assign cfg_valid  = cfg_valid_q;
  assign cfg_addr   = cfg_addr_q;
  assign cfg_data   = cfg_data_q;
  assign cmpl_valid = cmpl_valid_q;
  assign cmpl_id    = cmpl_id_q;

  // Config words are registered on entry to each SEND_* state, so cfg_valid
  // is high exactly while the FSM sits in SEND_ID/SEND_ADDR/SEND_LEN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      p_q          <= '0;
      id_q         <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      gap_q        <= '0;
      cfg_valid_q  <= 1'b0;
      cfg_addr_q   <= '0;
      cfg_data_q   <= '0;
      cmpl_valid_q <= 1'b0;
      cmpl_id_q    <= '0;
    end else begin
      cfg_valid_q  <= 1'b0;
      cfg_addr_q   <= '0;
      cfg_data_q   <= '0;
      cmpl_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            id_q   <= arb_idx;
            addr_q <= sel_addr;
            len_q  <= sel_len;
            p_q    <= (arb_idx == LAST_IDX) ? '0 : arb_idx + IW'(1);
            if (sel_len != '0) begin
              state_q     <= ST_SEND_ID;
              cfg_valid_q <= 1'b1;
              cfg_addr_q  <= ID_ADDR;
              cfg_data_q  <= ID_WORD;
            end else begin
              // Nothing for the engine to do: complete immediately.
              cmpl_valid_q <= 1'b1;
              cmpl_id_q    <= arb_idx;
              gap_q        <= '0;
              state_q      <= (CFG_GAP == 0) ? ST_IDLE : ST_GAP;
            end
          end
        end
        ST_SEND_ID: begin
          state_q     <= ST_SEND_ADDR;
          cfg_valid_q <= 1'b1;
          cfg_addr_q  <= DAT_ADDR;
          cfg_data_q  <= addr_q;
        end
        ST_SEND_ADDR: begin
          state_q     <= ST_SEND_LEN;
          cfg_valid_q <= 1'b1;
          cfg_addr_q  <= DAT_ADDR;
          cfg_data_q  <= len_q;
        end
        ST_SEND_LEN: begin
          state_q <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (done) begin
            cmpl_valid_q <= 1'b1;
            cmpl_id_q    <= id_q;
            gap_q        <= '0;
            state_q      <= (CFG_GAP == 0) ? ST_IDLE : ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q <= ST_IDLE;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_write_sched.sv
// tb/tb_axis_write_sched.sv - directed self-checking bench for axis_write_sched
module tb_axis_write_sched;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // DUT with default CFG_GAP=2
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_addr;
  logic [NR*DW-1:0] req_length;
  logic [NR-1:0]    req_ready;
  logic             done;
  logic [AW-1:0]    cfg_addr;
  logic [DW-1:0]    cfg_data;
  logic             cfg_valid;
  logic             cmpl_valid;
  logic [IW-1:0]    cmpl_id;
  logic             busy;

  // DUT built with CFG_GAP=0
  logic [NR-1:0]    z_req_valid;
  logic [NR*DW-1:0] z_req_addr;
  logic [NR*DW-1:0] z_req_length;
  logic [NR-1:0]    z_req_ready;
  logic             z_done;
  logic [AW-1:0]    z_cfg_addr;
  logic [DW-1:0]    z_cfg_data;
  logic             z_cfg_valid;
  logic             z_cmpl_valid;
  logic [IW-1:0]    z_cmpl_id;
  logic             z_busy;

  int checks = 0;
  int errors = 0;

  axis_write_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_length (req_length),
    .req_ready  (req_ready),
    .done       (done),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_valid  (cfg_valid),
    .cmpl_valid (cmpl_valid),
    .cmpl_id    (cmpl_id),
    .busy       (busy)
  );

  axis_write_sched #(.CFG_GAP(0)) dut_z (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (z_req_valid),
    .req_addr   (z_req_addr),
    .req_length (z_req_length),
    .req_ready  (z_req_ready),
    .done       (z_done),
    .cfg_addr   (z_cfg_addr),
    .cfg_data   (z_cfg_data),
    .cfg_valid  (z_cfg_valid),
    .cmpl_valid (z_cmpl_valid),
    .cmpl_id    (z_cmpl_id),
    .busy       (z_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks cfg_valid; address/data only matter when a word is expected.
  task automatic chk_cfg(input string tag, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    chk({tag, ".valid"}, 64'(cfg_valid), 64'(v));
    if (v) begin
      chk({tag, ".addr"}, 64'(cfg_addr), 64'(a));
      chk({tag, ".data"}, 64'(cfg_data), 64'(d));
    end
  endtask

  task automatic chk_zcfg(input string tag, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    chk({tag, ".valid"}, 64'(z_cfg_valid), 64'(v));
    if (v) begin
      chk({tag, ".addr"}, 64'(z_cfg_addr), 64'(a));
      chk({tag, ".data"}, 64'(z_cfg_data), 64'(d));
    end
  endtask

  task automatic set_desc(input int i, input logic [DW-1:0] a, input logic [DW-1:0] l);
    req_addr[i*DW +: DW]   = a;
    req_length[i*DW +: DW] = l;
  endtask

  initial begin
    logic [NR-1:0] exp_gnt;
    rst_n        = 1'b0;
    req_valid    = '0;
    req_addr     = '0;
    req_length   = '0;
    done         = 1'b0;
    z_req_valid  = '0;
    z_req_addr   = '0;
    z_req_length = '0;
    z_done       = 1'b0;

    // Reset state
    #3;
    chk("rst.cfg_valid", 64'(cfg_valid), 64'd0);
    chk("rst.cfg_addr", 64'(cfg_addr), 64'd0);
    chk("rst.cfg_data", 64'(cfg_data), 64'd0);
    chk("rst.cmpl_valid", 64'(cmpl_valid), 64'd0);
    chk("rst.cmpl_id", 64'(cmpl_id), 64'd0);
    chk("rst.req_ready", 64'(req_ready), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single request on requester 0
    set_desc(0, 32'h1000_0000, 32'd256);
    req_valid = 4'b0001;
    #1;
    chk("single.ready", 64'(req_ready), 64'b0001);
    chk("single.busy_idle", 64'(busy), 64'd0);
    tick();
    req_valid = '0;
    chk("single.ready_off", 64'(req_ready), 64'd0);
    chk("single.busy", 64'(busy), 64'd1);
    chk_cfg("single.id", 1'b1, 5'd23, 32'd1);
    tick();
    chk_cfg("single.addr", 1'b1, 5'd24, 32'h1000_0000);
    tick();
    chk_cfg("single.len", 1'b1, 5'd24, 32'd256);
    tick();
    chk_cfg("single.wait", 1'b0, 5'd0, 32'd0);
    tick();
    tick();
    chk("single.wait_busy", 64'(busy), 64'd1);
    chk("single.wait_cmpl", 64'(cmpl_valid), 64'd0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("single.cmpl_valid", 64'(cmpl_valid), 64'd1);
    chk("single.cmpl_id", 64'(cmpl_id), 64'd0);
    chk("single.gap_busy0", 64'(busy), 64'd1);
    tick();
    chk("single.cmpl_once", 64'(cmpl_valid), 64'd0);
    chk("single.gap_busy1", 64'(busy), 64'd1);
    tick();
    chk("single.idle", 64'(busy), 64'd0);

    // Spurious done in IDLE
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("spur_idle.cmpl", 64'(cmpl_valid), 64'd0);
    chk("spur_idle.busy", 64'(busy), 64'd0);

    // Requester 1 (pointer now 1); done pulsed during SEND_ADDR and SEND_LEN
    set_desc(1, 32'h2000_0040, 32'd64);
    req_valid = 4'b0010;
    #1;
    chk("spur.ready", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    chk_cfg("spur.id", 1'b1, 5'd23, 32'd1);
    tick();
    chk_cfg("spur.addr", 1'b1, 5'd24, 32'h2000_0040);
    done = 1'b1;
    tick();
    chk_cfg("spur.len", 1'b1, 5'd24, 32'd64);
    chk("spur.cmpl_sendlen", 64'(cmpl_valid), 64'd0);
    tick();
    done = 1'b0;
    chk_cfg("spur.wait", 1'b0, 5'd0, 32'd0);
    chk("spur.cmpl_wait", 64'(cmpl_valid), 64'd0);
    chk("spur.busy", 64'(busy), 64'd1);
    tick();
    chk("spur.still_wait", 64'(cmpl_valid), 64'd0);
    chk("spur.still_busy", 64'(busy), 64'd1);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("spur.cmpl_valid", 64'(cmpl_valid), 64'd1);
    chk("spur.cmpl_id", 64'(cmpl_id), 64'd1);
    tick();
    chk("spur.cmpl_once", 64'(cmpl_valid), 64'd0);
    tick();
    chk("spur.idle", 64'(busy), 64'd0);

    // Zero-length descriptor on requester 2 (pointer now 2)
    set_desc(2, 32'h3000_0000, 32'd0);
    req_valid = 4'b0100;
    #1;
    chk("zero.ready", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0;
    chk("zero.no_cfg", 64'(cfg_valid), 64'd0);
    chk("zero.cmpl_valid", 64'(cmpl_valid), 64'd1);
    chk("zero.cmpl_id", 64'(cmpl_id), 64'd2);
    chk("zero.gap_busy0", 64'(busy), 64'd1);
    tick();
    chk("zero.no_cfg1", 64'(cfg_valid), 64'd0);
    chk("zero.cmpl_once", 64'(cmpl_valid), 64'd0);
    chk("zero.gap_busy1", 64'(busy), 64'd1);
    tick();
    chk("zero.idle", 64'(busy), 64'd0);

    // Reset during SEND_ADDR; pointer is 3 before reset
    set_desc(2, 32'h4000_0000, 32'd8);
    req_valid = 4'b0100;
    #1;
    chk("rstmid.ready", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0;
    chk_cfg("rstmid.id", 1'b1, 5'd23, 32'd1);
    tick();
    chk_cfg("rstmid.addr", 1'b1, 5'd24, 32'h4000_0000);
    rst_n = 1'b0;
    #1;
    chk("rstmid.cfg_valid", 64'(cfg_valid), 64'd0);
    chk("rstmid.busy", 64'(busy), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) begin
      set_desc(i, 32'hA000_0000 + 32'(i * 256), 32'(16 + i));
    end
    req_valid = 4'b1100;
    #1;
    chk("rstmid.ptr0_grant", 64'(req_ready), 64'b0100);
    chk("rstmid.no_cfg", 64'(cfg_valid), 64'd0);
    req_valid = 4'b1111;
    #1;
    chk("rstmid.all_grant", 64'(req_ready), 64'b0001);

    // Round robin with all requesters continuously valid
    for (int n = 0; n < 5; n++) begin
      exp_gnt = 4'b0001 << (n % 4);
      chk($sformatf("rr%0d.ready", n), 64'(req_ready), 64'(exp_gnt));
      tick();
      chk_cfg($sformatf("rr%0d.id", n), 1'b1, 5'd23, 32'd1);
      tick();
      chk_cfg($sformatf("rr%0d.addr", n), 1'b1, 5'd24, 32'hA000_0000 + 32'((n % 4) * 256));
      tick();
      chk_cfg($sformatf("rr%0d.len", n), 1'b1, 5'd24, 32'(16 + (n % 4)));
      tick();
      tick();
      tick();
      tick();
      chk($sformatf("rr%0d.busy", n), 64'(busy), 64'd1);
      chk($sformatf("rr%0d.ready_off", n), 64'(req_ready), 64'd0);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk($sformatf("rr%0d.cmpl_valid", n), 64'(cmpl_valid), 64'd1);
      chk($sformatf("rr%0d.cmpl_id", n), 64'(cmpl_id), 64'(n % 4));
      tick();
      tick();
    end
    req_valid = '0;

    // CFG_GAP=0 build: pending request accepted in the cycle after done
    z_req_addr[0 +: DW]    = 32'h5000_0000;
    z_req_length[0 +: DW]  = 32'd4;
    z_req_addr[DW +: DW]   = 32'h6000_0000;
    z_req_length[DW +: DW] = 32'd5;
    z_req_valid = 4'b0011;
    #1;
    chk("gap0.ready0", 64'(z_req_ready), 64'b0001);
    tick();
    z_req_valid = 4'b0010;
    chk_zcfg("gap0.id0", 1'b1, 5'd23, 32'd1);
    tick();
    chk_zcfg("gap0.addr0", 1'b1, 5'd24, 32'h5000_0000);
    tick();
    chk_zcfg("gap0.len0", 1'b1, 5'd24, 32'd4);
    tick();
    chk_zcfg("gap0.wait0", 1'b0, 5'd0, 32'd0);
    chk("gap0.ready_wait", 64'(z_req_ready), 64'd0);
    z_done = 1'b1;
    tick();
    z_done = 1'b0;
    chk("gap0.cmpl_valid0", 64'(z_cmpl_valid), 64'd1);
    chk("gap0.cmpl_id0", 64'(z_cmpl_id), 64'd0);
    chk("gap0.idle", 64'(z_busy), 64'd0);
    chk("gap0.ready1", 64'(z_req_ready), 64'b0010);
    tick();
    z_req_valid = '0;
    chk_zcfg("gap0.id1", 1'b1, 5'd23, 32'd1);
    chk("gap0.cmpl_once", 64'(z_cmpl_valid), 64'd0);
    tick();
    chk_zcfg("gap0.addr1", 1'b1, 5'd24, 32'h6000_0000);
    tick();
    chk_zcfg("gap0.len1", 1'b1, 5'd24, 32'd5);
    tick();
    z_done = 1'b1;
    tick();
    z_done = 1'b0;
    chk("gap0.cmpl_valid1", 64'(z_cmpl_valid), 64'd1);
    chk("gap0.cmpl_id1", 64'(z_cmpl_id), 64'd1);
    chk("gap0.idle1", 64'(z_busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
